// File: rtl/mem_stage.sv
// Memory stage: drives a variable-latency data memory over a req/done handshake,
// stalls upstream until each access completes, and loads the MEM/WB register.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALUO_EXMEM,
  input  logic [15:0] Rd2_EXMEM,
  input  logic [2:0]  WrR_EXMEM,
  input  logic        MemtoReg_EXMEM,
  input  logic        MemWrite_EXMEM,
  input  logic        MemRead_EXMEM,
  input  logic        RegWrite_EXMEM,
  input  logic        Dump_EXMEM,
  input  logic        halt_EXMEM,
  input  logic        jumpAndLink_EXMEM,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        stall,
  output logic [15:0] ALUO_MEMWB,
  output logic [15:0] MemData_MEMWB,
  output logic [2:0]  WrR_MEMWB,
  output logic        RegWrite_MEMWB,
  output logic        MemtoReg_MEMWB,
  output logic        Dump_MEMWB,
  output logic        halt_MEMWB,
  output logic        jumpAndLink_MEMWB,
  output logic [15:0] stall_cnt,
  output logic        err
);
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {IDLE, BUSY, FAULT} state_t;
  state_t state;

  logic access, misalign, faulted, wr_req, rd_req;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // A simultaneous read+write request is treated as a write.
  always_comb begin
    access   = MemRead_EXMEM | MemWrite_EXMEM;
    misalign = access & ALUO_EXMEM[0];
    faulted  = (state == FAULT);
    wr_req   = MemWrite_EXMEM & ~misalign & ~faulted;
    rd_req   = MemRead_EXMEM & ~MemWrite_EXMEM & ~misalign & ~faulted;
    mem_rd   = rd_req & ~rst;
    mem_wr   = wr_req & ~rst;
    stall    = (access & ~mem_done & ~misalign) | faulted | misalign;
  end

  assign mem_addr  = ALUO_EXMEM;
  assign mem_wdata = Rd2_EXMEM;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (misalign) begin
            state <= FAULT;
            err   <= 1'b1;
          end else if (access && !mem_done) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (misalign) begin
            state <= FAULT;
            err   <= 1'b1;
          end else if (mem_done || !access) begin
            state <= IDLE;
          end
        end
        FAULT:   state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB boundary: bubble while stalled; halt is raised from the faulting edge on
  always_ff @(posedge clk) begin
    if (rst) begin
      ALUO_MEMWB        <= '0;
      MemData_MEMWB     <= '0;
      WrR_MEMWB         <= '0;
      RegWrite_MEMWB    <= 1'b0;
      MemtoReg_MEMWB    <= 1'b0;
      Dump_MEMWB        <= 1'b0;
      halt_MEMWB        <= 1'b0;
      jumpAndLink_MEMWB <= 1'b0;
    end else if (stall) begin
      ALUO_MEMWB        <= '0;
      MemData_MEMWB     <= '0;
      WrR_MEMWB         <= '0;
      RegWrite_MEMWB    <= 1'b0;
      MemtoReg_MEMWB    <= 1'b0;
      Dump_MEMWB        <= 1'b0;
      halt_MEMWB        <= faulted | misalign;
      jumpAndLink_MEMWB <= 1'b0;
    end else begin
      ALUO_MEMWB        <= ALUO_EXMEM;
      MemData_MEMWB     <= rd_req ? mem_rdata : '0;
      WrR_MEMWB         <= WrR_EXMEM;
      RegWrite_MEMWB    <= RegWrite_EXMEM;
      MemtoReg_MEMWB    <= MemtoReg_EXMEM;
      Dump_MEMWB        <= Dump_EXMEM;
      halt_MEMWB        <= halt_EXMEM;
      jumpAndLink_MEMWB <= jumpAndLink_EXMEM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        stall_cnt <= '0;
    else if (stall) stall_cnt <= sat_inc(stall_cnt);
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage: each task drives one scenario and checks inline.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ALUO_EXMEM, Rd2_EXMEM, mem_rdata;
  logic [2:0]  WrR_EXMEM;
  logic        MemtoReg_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, RegWrite_EXMEM;
  logic        Dump_EXMEM, halt_EXMEM, jumpAndLink_EXMEM, mem_done;
  logic [15:0] mem_addr, mem_wdata, ALUO_MEMWB, MemData_MEMWB, stall_cnt;
  logic [2:0]  WrR_MEMWB;
  logic        mem_rd, mem_wr, stall, RegWrite_MEMWB, MemtoReg_MEMWB, Dump_MEMWB;
  logic        halt_MEMWB, jumpAndLink_MEMWB, err;

  int total = 0;
  int bad = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ALUO_EXMEM(ALUO_EXMEM), .Rd2_EXMEM(Rd2_EXMEM), .WrR_EXMEM(WrR_EXMEM),
    .MemtoReg_EXMEM(MemtoReg_EXMEM), .MemWrite_EXMEM(MemWrite_EXMEM),
    .MemRead_EXMEM(MemRead_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM),
    .Dump_EXMEM(Dump_EXMEM), .halt_EXMEM(halt_EXMEM), .jumpAndLink_EXMEM(jumpAndLink_EXMEM),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .stall(stall),
    .ALUO_MEMWB(ALUO_MEMWB), .MemData_MEMWB(MemData_MEMWB), .WrR_MEMWB(WrR_MEMWB),
    .RegWrite_MEMWB(RegWrite_MEMWB), .MemtoReg_MEMWB(MemtoReg_MEMWB),
    .Dump_MEMWB(Dump_MEMWB), .halt_MEMWB(halt_MEMWB), .jumpAndLink_MEMWB(jumpAndLink_MEMWB),
    .stall_cnt(stall_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ALUO_EXMEM = '0; Rd2_EXMEM = '0; WrR_EXMEM = '0; mem_rdata = '0; mem_done = 1'b0;
    MemtoReg_EXMEM = 1'b0; MemWrite_EXMEM = 1'b0; MemRead_EXMEM = 1'b0;
    RegWrite_EXMEM = 1'b0; Dump_EXMEM = 1'b0; halt_EXMEM = 1'b0; jumpAndLink_EXMEM = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    cycle(); cycle();
    total++; if (ALUO_MEMWB !== 16'h0) begin bad++; $display("FAIL reset_aluo got=%h exp=0000", ALUO_MEMWB); end
    total++; if (halt_MEMWB !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", halt_MEMWB); end
    total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0000", stall_cnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    MemRead_EXMEM = 1'b1; ALUO_EXMEM = 16'h0040;
    #1;
    total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", mem_rd); end
    cycle();
    clear_inputs();
    rst = 1'b0;
    cycle();
    total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt_hold got=%h exp=0000", stall_cnt); end
  endtask

  task automatic test_passthru();
    ALUO_EXMEM = 16'h1234; RegWrite_EXMEM = 1'b1; WrR_EXMEM = 3'd5;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL pass_stall got=%b exp=0", stall); end
    total++; if ({mem_rd, mem_wr} !== 2'b00) begin bad++; $display("FAIL pass_strobe got=%b exp=00", {mem_rd, mem_wr}); end
    cycle();
    total++; if (ALUO_MEMWB !== 16'h1234) begin bad++; $display("FAIL pass_aluo got=%h exp=1234", ALUO_MEMWB); end
    total++; if (WrR_MEMWB !== 3'd5) begin bad++; $display("FAIL pass_wrr got=%0d exp=5", WrR_MEMWB); end
    total++; if (RegWrite_MEMWB !== 1'b1) begin bad++; $display("FAIL pass_regwrite got=%b exp=1", RegWrite_MEMWB); end
    clear_inputs();
  endtask

  task automatic test_load_3cyc();
    MemRead_EXMEM = 1'b1; ALUO_EXMEM = 16'h0040; RegWrite_EXMEM = 1'b1;
    MemtoReg_EXMEM = 1'b1; WrR_EXMEM = 3'd3;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin mem_done = 1'b1; mem_rdata = 16'hBEEF; end
      #1;
      total++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0040) begin bad++; $display("FAIL load_rd_c%0d got=%b/%h exp=1/0040", c, mem_rd, mem_addr); end
      total++; if (stall !== (c < 3)) begin bad++; $display("FAIL load_stall_c%0d got=%b exp=%b", c, stall, c < 3); end
      cycle();
      if (c < 3) begin
        total++; if (RegWrite_MEMWB !== 1'b0 || MemData_MEMWB !== 16'h0) begin bad++; $display("FAIL load_bubble_c%0d got=%b/%h exp=0/0000", c, RegWrite_MEMWB, MemData_MEMWB); end
      end
    end
    total++; if (MemData_MEMWB !== 16'hBEEF) begin bad++; $display("FAIL load_data got=%h exp=beef", MemData_MEMWB); end
    total++; if ({RegWrite_MEMWB, MemtoReg_MEMWB, WrR_MEMWB} !== 5'b11_011) begin bad++; $display("FAIL load_ctrl got=%b exp=11011", {RegWrite_MEMWB, MemtoReg_MEMWB, WrR_MEMWB}); end
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL load_cnt got=%0d exp=2", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_store_hit();
    MemWrite_EXMEM = 1'b1; ALUO_EXMEM = 16'h0010; Rd2_EXMEM = 16'hA5A5; mem_done = 1'b1;
    #1;
    total++; if ({mem_wr, mem_rd} !== 2'b10) begin bad++; $display("FAIL store_strobe got=%b exp=10", {mem_wr, mem_rd}); end
    total++; if (mem_wdata !== 16'hA5A5 || mem_addr !== 16'h0010) begin bad++; $display("FAIL store_bus got=%h/%h exp=a5a5/0010", mem_wdata, mem_addr); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL store_stall got=%b exp=0", stall); end
    cycle();
    clear_inputs();
    #1;
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL store_wr_drop got=%b exp=0", mem_wr); end
    total++; if (RegWrite_MEMWB !== 1'b0 || ALUO_MEMWB !== 16'h0010) begin bad++; $display("FAIL store_memwb got=%b/%h exp=0/0010", RegWrite_MEMWB, ALUO_MEMWB); end
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL store_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    MemRead_EXMEM = 1'b1; ALUO_EXMEM = 16'h0020; WrR_EXMEM = 3'd1; RegWrite_EXMEM = 1'b1;
    mem_done = 1'b1; mem_rdata = 16'h1111;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_hit_stall got=%b exp=0", stall); end
    cycle();
    total++; if (MemData_MEMWB !== 16'h1111) begin bad++; $display("FAIL b2b_first got=%h exp=1111", MemData_MEMWB); end
    ALUO_EXMEM = 16'h0022; mem_done = 1'b0; mem_rdata = 16'hDEAD;
    #1;
    total++; if (mem_rd !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL b2b_second_req got=%b%b exp=11", mem_rd, stall); end
    cycle();
    total++; if (MemData_MEMWB !== 16'h0 || RegWrite_MEMWB !== 1'b0) begin bad++; $display("FAIL b2b_bubble got=%h/%b exp=0000/0", MemData_MEMWB, RegWrite_MEMWB); end
    mem_done = 1'b1; mem_rdata = 16'h2222;
    cycle();
    total++; if (MemData_MEMWB !== 16'h2222) begin bad++; $display("FAIL b2b_second got=%h exp=2222", MemData_MEMWB); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL b2b_cnt got=%0d exp=3", stall_cnt); end
    // Stray done with no request, then a read+write that must be treated as a write.
    clear_inputs(); mem_done = 1'b1; mem_rdata = 16'hFFFF;
    cycle();
    total++; if (MemData_MEMWB !== 16'h0 || stall_cnt !== 16'd3) begin bad++; $display("FAIL stray_done got=%h/%0d exp=0000/3", MemData_MEMWB, stall_cnt); end
    MemRead_EXMEM = 1'b1; MemWrite_EXMEM = 1'b1; ALUO_EXMEM = 16'h0030;
    #1;
    total++; if ({mem_wr, mem_rd} !== 2'b10) begin bad++; $display("FAIL rw_is_write got=%b exp=10", {mem_wr, mem_rd}); end
    cycle();
    total++; if (err !== 1'b0 || MemData_MEMWB !== 16'h0) begin bad++; $display("FAIL rw_result got=%b/%h exp=0/0000", err, MemData_MEMWB); end
    clear_inputs();
  endtask

  task automatic test_reset_busy();
    MemRead_EXMEM = 1'b1; ALUO_EXMEM = 16'h0050; RegWrite_EXMEM = 1'b1; WrR_EXMEM = 3'd6;
    cycle();
    rst = 1'b1;
    #1;
    total++; if ({mem_rd, mem_wr} !== 2'b00) begin bad++; $display("FAIL rbusy_strobe got=%b exp=00", {mem_rd, mem_wr}); end
    cycle();
    total++; if ({ALUO_MEMWB, MemData_MEMWB, WrR_MEMWB, RegWrite_MEMWB, MemtoReg_MEMWB, Dump_MEMWB, halt_MEMWB, jumpAndLink_MEMWB} !== 40'h0) begin bad++; $display("FAIL rbusy_memwb got=%h/%h exp=0000/0000", ALUO_MEMWB, MemData_MEMWB); end
    total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL rbusy_cnt got=%0d exp=0", stall_cnt); end
    rst = 1'b0; mem_done = 1'b1; mem_rdata = 16'h5555;
    #1;
    total++; if (mem_rd !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL rbusy_fresh_req got=%b%b exp=10", mem_rd, stall); end
    cycle();
    total++; if (MemData_MEMWB !== 16'h5555 || WrR_MEMWB !== 3'd6) begin bad++; $display("FAIL rbusy_fresh_data got=%h/%0d exp=5555/6", MemData_MEMWB, WrR_MEMWB); end
    clear_inputs();
  endtask

  task automatic test_misalign();
    MemRead_EXMEM = 1'b1; ALUO_EXMEM = 16'h0011; RegWrite_EXMEM = 1'b1; mem_done = 1'b1;
    #1;
    total++; if ({mem_rd, mem_wr} !== 2'b00) begin bad++; $display("FAIL mis_strobe got=%b exp=00", {mem_rd, mem_wr}); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mis_stall got=%b exp=1", stall); end
    cycle();
    total++; if (err !== 1'b1 || halt_MEMWB !== 1'b1 || RegWrite_MEMWB !== 1'b0) begin bad++; $display("FAIL mis_fault got=%b%b%b exp=110", err, halt_MEMWB, RegWrite_MEMWB); end
    clear_inputs(); MemWrite_EXMEM = 1'b1; ALUO_EXMEM = 16'h0010; mem_done = 1'b1;
    cycle(); cycle();
    total++; if (stall !== 1'b1 || mem_wr !== 1'b0) begin bad++; $display("FAIL mis_stuck got=%b%b exp=10", stall, mem_wr); end
    total++; if (halt_MEMWB !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL mis_hold got=%b%b exp=11", halt_MEMWB, err); end
    clear_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    total++; if (err !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mis_reset got=%b%b exp=00", err, stall); end
    ALUO_EXMEM = 16'h0777; RegWrite_EXMEM = 1'b1;
    cycle();
    total++; if (ALUO_MEMWB !== 16'h0777 || halt_MEMWB !== 1'b0) begin bad++; $display("FAIL mis_idle_again got=%h/%b exp=0777/0", ALUO_MEMWB, halt_MEMWB); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    MemRead_EXMEM = 1'b1; ALUO_EXMEM = 16'h0040;
    repeat (65534) cycle();
    total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_near got=%h exp=fffe", stall_cnt); end
    repeat (6) cycle();
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_load_3cyc();
    test_store_hit();
    test_back_to_back();
    test_reset_busy();
    test_misalign();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
